// File: rtl/ldst_sequencer.sv
// ldst_sequencer: multi-cycle load/store controller driving register-file and data-memory ports.
// Optional LDST_ADDR_CHECK_EN adds an err output and aborts on address overflow.
module ldst_sequencer #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              op,
  input  logic [REG_W-1:0]  rd_rs,
  input  logic [REG_W-1:0]  base,
  input  logic [ADDR_W-1:0] offset,
  output logic              ready,
  output logic              done,
`ifdef LDST_ADDR_CHECK_EN
  output logic              err,
`endif
  output logic [REG_W-1:0]  rf_ra,
  output logic [REG_W-1:0]  rf_rb,
  input  logic [DATA_W-1:0] rf_douta,
  input  logic [DATA_W-1:0] rf_doutb,
  output logic [REG_W-1:0]  rf_rw,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  typedef enum logic [2:0] {IDLE, READ, ADDR, MEM, WB, ABRT} state_t;
  state_t state_q, state_d;
  logic op_q, op_d;
  logic [REG_W-1:0] rd_rs_q, rd_rs_d, base_q, base_d;
  logic [ADDR_W-1:0] offset_q, offset_d, addr_q, addr_d, sum;
  logic [DATA_W-1:0] data_q, data_d;
  logic carry, bad;
  assign {carry, sum} = {1'b0, rf_doutb[ADDR_W-1:0]} + {1'b0, offset_q};
`ifdef LDST_ADDR_CHECK_EN
  assign bad = carry | (|rf_doutb[DATA_W-1:ADDR_W]);
`else
  logic unused_hi;
  assign unused_hi = carry ^ (^rf_doutb[DATA_W-1:ADDR_W]);
  assign bad = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    rd_rs_d = rd_rs_q;
    base_d = base_q;
    offset_d = offset_q;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (req) begin
        op_d = op;
        rd_rs_d = rd_rs;
        base_d = base;
        offset_d = offset;
        state_d = READ;
      end
      READ: state_d = ADDR;
      ADDR: begin
        addr_d = sum;
        data_d = rf_douta;
        state_d = bad ? ABRT : MEM;
      end
      MEM: state_d = op_q ? IDLE : WB;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= 1'b0;
      rd_rs_q <= '0;
      base_q <= '0;
      offset_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      rd_rs_q <= rd_rs_d;
      base_q <= base_d;
      offset_q <= offset_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  // Outputs decode straight from state so reset clears every strobe asynchronously.
  assign ready = state_q == IDLE;
  assign done = (state_q == MEM && op_q) || state_q == WB || state_q == ABRT;
`ifdef LDST_ADDR_CHECK_EN
  assign err = state_q == ABRT;
`endif
  assign rf_ra = ready ? '0 : rd_rs_q;
  assign rf_rb = ready ? '0 : base_q;
  assign rf_we = state_q == WB;
  assign rf_rw = rf_we ? rd_rs_q : '0;
  assign rf_din = rf_we ? mem_dout : '0;
  assign mem_addr = state_q == MEM ? addr_q : '0;
  assign mem_we = state_q == MEM && op_q;
  assign mem_din = mem_we ? data_q : '0;
endmodule
